// File: rtl/conv_stream_engine.sv
// conv_stream_engine
//   Valid-mode 2-D convolution of an IMG x IMG unsigned image with a
//   KER x KER unsigned kernel. The kernel and then the image are streamed
//   into internal buffers. Results come back in raster order over a
//   valid/ready stream.
//   Two evaluation modes:
//     MODE=0 : one tap per cycle
//     MODE=1 : one kernel row per cycle
//   Two narrowing modes:
//     SAT=0  : wrap
//     SAT=1  : saturate
//
// Ports
//   i_clk, i_rst_n           clock, synchronous active-low reset
//   i_start, i_mode, i_sat   run request; mode/sat are latched on accept
//   i_in_valid/o_in_ready    load stream handshake
//   i_in_data                kernel words (raster), then image words (raster)
//   o_out_valid/i_out_ready  result stream handshake
//   o_out                    result narrowed to DW bits
//   o_out_acc                full-precision result
//   o_out_last               high with the final result of a run
//   o_busy                   high whenever not idle
module conv_stream_engine #(
  parameter int DW    = 8,
  parameter int IMG   = 4,
  parameter int KER   = 3,
  parameter int ACC_W = 2*DW + $clog2(KER*KER)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_mode,
  input  logic             i_sat,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [DW-1:0]    i_in_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [DW-1:0]    o_out,
  output logic [ACC_W-1:0] o_out_acc,
  output logic             o_out_last,
  output logic             o_busy
);
  localparam int NK = KER*KER;
  localparam int NI = IMG*IMG;
  localparam int NW = NK + NI;
  localparam int NO = IMG - KER + 1;
  localparam int LW = (NW > 1) ? $clog2(NW) : 1;
  localparam int CW = (NO > 1) ? $clog2(NO) : 1;
  localparam int KW = (KER > 1) ? $clog2(KER) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_CALC = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]       r_state;
  logic             r_mode, r_sat;
  logic [LW-1:0]    r_ld_cnt;
  logic [CW-1:0]    r_oi, r_oj;    // output coordinate
  logic [KW-1:0]    r_tr, r_tc;    // current tap row/col
  logic [ACC_W-1:0] r_acc;
  logic [NK*DW-1:0] r_kbuf;        // flat buffers, not cleared by reset
  logic [NI*DW-1:0] r_ibuf;

  logic [2*DW-1:0]  w_prod;
  logic [ACC_W-1:0] w_term;
  logic             w_first_tap, w_last_tap, w_last_out;

  // Contribution of this cycle: a single tap (MODE=0) or the whole
  // kernel row r_tr (MODE=1). In MODE=1 r_tc stays 0 and is ignored.
  always_comb begin
    w_term = '0;
    w_prod = '0;
    for (int c = 0; c < KER; c++) begin
      if (r_mode || c == int'(r_tc)) begin
        w_prod = (2*DW)'(r_kbuf[(int'(r_tr)*KER + c)*DW +: DW]) *
                 (2*DW)'(r_ibuf[((int'(r_oi) + int'(r_tr))*IMG + int'(r_oj) + c)*DW +: DW]);
        w_term = w_term + ACC_W'(w_prod);
      end
    end
  end

  assign w_first_tap = (r_tr == '0) && (r_tc == '0);
  assign w_last_tap  = (r_tr == KW'(KER-1)) && (r_mode || r_tc == KW'(KER-1));
  assign w_last_out  = (r_oi == CW'(NO-1)) && (r_oj == CW'(NO-1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_mode   <= 1'b0;
      r_sat    <= 1'b0;
      r_ld_cnt <= '0;
      r_oi     <= '0;
      r_oj     <= '0;
      r_tr     <= '0;
      r_tc     <= '0;
      r_acc    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_mode   <= i_mode;
          r_sat    <= i_sat;
          r_ld_cnt <= '0;
          r_state  <= S_LOAD;
        end
        S_LOAD: if (i_in_valid) begin
          if (r_ld_cnt < LW'(NK))
            r_kbuf[int'(r_ld_cnt)*DW +: DW] <= i_in_data;
          else
            r_ibuf[(int'(r_ld_cnt) - NK)*DW +: DW] <= i_in_data;
          if (r_ld_cnt == LW'(NW-1)) begin
            r_ld_cnt <= '0;
            r_oi     <= '0;
            r_oj     <= '0;
            r_tr     <= '0;
            r_tc     <= '0;
            r_state  <= S_CALC;
          end else begin
            r_ld_cnt <= r_ld_cnt + 1'b1;
          end
        end
        S_CALC: begin
          // The first tap of each output overwrites the stale sum.
          r_acc <= w_first_tap ? w_term : r_acc + w_term;
          if (w_last_tap) begin
            r_state <= S_HOLD;
          end else if (r_mode || r_tc == KW'(KER-1)) begin
            r_tc <= '0;
            r_tr <= r_tr + 1'b1;
          end else begin
            r_tc <= r_tc + 1'b1;
          end
        end
        S_HOLD: if (i_out_ready) begin
          r_tr <= '0;
          r_tc <= '0;
          if (w_last_out) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_CALC;
            if (r_oj == CW'(NO-1)) begin
              r_oj <= '0;
              r_oi <= r_oi + 1'b1;
            end else begin
              r_oj <= r_oj + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_in_ready  = (r_state == S_LOAD);
  assign o_out_valid = (r_state == S_HOLD);
  assign o_out_last  = (r_state == S_HOLD) && w_last_out;
  assign o_busy      = (r_state != S_IDLE);
  assign o_out_acc   = r_acc;
  assign o_out       = (r_sat && (r_acc[ACC_W-1:DW] != '0)) ? {DW{1'b1}} : r_acc[DW-1:0];

endmodule

// File: tb/tb_conv_stream_engine.sv
module tb_conv_stream_engine;
  localparam int DW    = 8;
  localparam int IMG   = 4;
  localparam int KER   = 3;
  localparam int ACC_W = 2*DW + $clog2(KER*KER);
  localparam int NK    = KER*KER;
  localparam int NI    = IMG*IMG;
  localparam int NW    = NK + NI;
  localparam int NO    = IMG - KER + 1;

  logic             clk = 1'b0;
  logic             rst_n, start, mode, sat, in_valid, in_ready;
  logic [DW-1:0]    in_data;
  logic             out_valid, out_ready, out_last, busy;
  logic [DW-1:0]    out;
  logic [ACC_W-1:0] out_acc;

  always #5 clk = ~clk;

  conv_stream_engine #(.DW(DW), .IMG(IMG), .KER(KER), .ACC_W(ACC_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_mode(mode), .i_sat(sat),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out(out),
    .o_out_acc(out_acc), .o_out_last(out_last), .o_busy(busy)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  logic [DW-1:0] kern [NK];
  logic [DW-1:0] img  [NI];

  // One full run: start, load, drain every output.
  // hold < 0 picks a random backpressure length per output.
  // rst_at >= 0 aborts with a one-cycle reset during CALC of output rst_at+1.
  task automatic run(input bit m, input bit s, input bit stall, input int hold,
                     input bit pulse, input bit chk_lat, input int rst_at);
    longint exp_acc [NO*NO];
    longint e, eo;
    int idx, guard, lat, g, h;
    bit tog, acc_xfer;
    logic [DW-1:0]    v_out;
    logic [ACC_W-1:0] v_acc;

    for (int oi = 0; oi < NO; oi++)
      for (int oj = 0; oj < NO; oj++) begin
        e = 0;
        for (int r = 0; r < KER; r++)
          for (int c = 0; c < KER; c++)
            e += longint'(img[(oi+r)*IMG + oj + c]) * longint'(kern[r*KER + c]);
        exp_acc[oi*NO + oj] = e;
      end

    @(negedge clk);
    start = 1; mode = m; sat = s;
    @(negedge clk);
    start = 0;
    chk("busy_after_start", busy, 1);
    chk("in_ready_load", in_ready, 1);

    idx = 0; guard = 0; tog = 0;
    while (idx < NW && guard < 1000) begin
      if (stall && tog) begin
        in_valid = 0;
        start = pulse;
      end else begin
        in_valid = 1;
        in_data = (idx < NK) ? kern[idx] : img[idx-NK];
        start = 0;
      end
      tog = !tog;
      acc_xfer = in_valid && in_ready;
      @(negedge clk);
      if (acc_xfer) idx++;
      guard++;
    end
    in_valid = 0;
    start = 0;
    chk("load_done", idx, NW);
    chk("in_ready_calc", in_ready, 0);

    // Now in the first CALC cycle.
    lat = 0;
    while (!out_valid && lat < 200) begin
      start = pulse && (lat == 1);
      lat++;
      @(negedge clk);
    end
    start = 0;
    if (chk_lat) chk("latency", lat, m ? KER : NK);

    for (int k = 0; k < NO*NO; k++) begin
      g = 0;
      while (!out_valid && g < 200) begin
        @(negedge clk);
        g++;
      end
      chk("out_valid", out_valid, 1);
      v_out = out;
      v_acc = out_acc;
      h = (hold < 0) ? int'($urandom_range(0, 3)) : hold;
      repeat (h) begin
        @(negedge clk);
        chk("hold_valid", out_valid, 1);
        chk("hold_acc", out_acc, v_acc);
        chk("hold_out", out, v_out);
      end
      e  = exp_acc[k];
      eo = (s && e > 255) ? 255 : (e & 255);
      chk("acc", out_acc, e);
      chk("out", out, eo);
      chk("last", out_last, (k == NO*NO-1));
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
      chk("valid_drop", out_valid, 0);
      if (k == rst_at) begin
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_acc", out_acc, 0);
        chk("rst_ready", in_ready, 0);
        rst_n = 1;
        return;
      end
    end
    chk("idle_after_run", busy, 0);
  endtask

  task automatic rand_data();
    for (int i = 0; i < NK; i++) kern[i] = DW'($urandom);
    for (int i = 0; i < NI; i++) img[i]  = DW'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst_n = 0; start = 0; mode = 0; sat = 0;
    in_valid = 0; in_data = '0; out_ready = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy0", busy, 0);
    chk("rst_in_ready0", in_ready, 0);
    chk("rst_valid0", out_valid, 0);
    chk("rst_last0", out_last, 0);
    chk("rst_out0", out, 0);
    chk("rst_acc0", out_acc, 0);
    rst_n = 1;
    @(negedge clk);
    chk("idle_no_start", busy, 0);

    // All ones, serial, wrap.
    for (int i = 0; i < NK; i++) kern[i] = 1;
    for (int i = 0; i < NI; i++) img[i]  = 1;
    run(0, 0, 0, 0, 0, 1, -1);

    // Centre-tap kernel on 1..16, row-parallel.
    for (int i = 0; i < NK; i++) kern[i] = (i == NK/2) ? 1 : 0;
    for (int i = 0; i < NI; i++) img[i]  = DW'(i + 1);
    run(1, 0, 0, 0, 0, 1, -1);

    // Full-scale operands: saturate then wrap.
    for (int i = 0; i < NK; i++) kern[i] = 8'hFF;
    for (int i = 0; i < NI; i++) img[i]  = 8'hFF;
    run(0, 1, 0, 0, 0, 0, -1);
    run(1, 0, 0, 0, 0, 0, -1);

    // Backpressure of 5 cycles on every output.
    rand_data();
    run(0, 1, 0, 5, 0, 0, -1);

    // Stalled load with ignored START pulses, same data, other mode.
    run(1, 1, 1, 0, 1, 1, -1);

    // Reset during CALC of the second output, then a clean run.
    rand_data();
    run(0, 0, 0, 0, 0, 0, 0);
    run(0, 0, 0, 0, 0, 1, -1);

    // Random runs.
    for (int t = 0; t < 8; t++) begin
      rand_data();
      run(1'($urandom), 1'($urandom), 1'($urandom), -1, 1'($urandom), 1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/conv_stream_engine.md
Name: conv_stream_engine

Overview:
Parametrised successor to the fixed 4x4-image / 3x3-kernel computation block. It produces valid-mode 2-D convolution outputs of an IMG x IMG unsigned image with a KER x KER unsigned kernel. Operands are loaded over a valid/ready stream into internal buffers. Outputs are returned in raster order over a valid/ready stream with backpressure. A run-time MODE selects serial (single-MAC) or row-parallel (KER-MAC) evaluation, and SAT selects wrap or saturate output narrowing.

Parameters:
DW, 8, pixel/weight/output width in bits (unsigned)
IMG, 4, image side length; IMG >= KER
KER, 3, kernel side length; KER >= 1
ACC_W, 2*DW+clog2(KER*KER), accumulator width; never overflows

Ports:
CLK  input  1  clock; all state changes on rising edge
RST  input  1  synchronous, active-low reset
START  input  1  one-cycle request to begin a run; honoured only in IDLE
MODE  input  1  0 = serial, 1 = row-parallel; sampled when START is accepted
SAT  input  1  0 = wrap (low DW bits), 1 = saturate; sampled when START is accepted
IN_VALID  input  1  IN_DATA valid
IN_READY  output  1  block accepts IN_DATA; high only in LOAD
IN_DATA  input  DW  kernel words first (KER*KER, raster), then image words (IMG*IMG, raster)
OUT_VALID  output  1  OUT/OUT_ACC valid
OUT_READY  input  1  consumer accepts output
OUT  output  DW  narrowed result
OUT_ACC  output  ACC_W  full-precision result
OUT_LAST  output  1  high with the final output of a run
BUSY  output  1  high in any state other than IDLE

Behaviour:
- Reset (RST=0 at a clock edge): state goes to IDLE. IN_READY, OUT_VALID, OUT_LAST and BUSY are 0. OUT and OUT_ACC are 0. All counters and the accumulator are 0. Buffer contents are not cleared. Reset wins over every other input in the same cycle, including mid-load, mid-calc and while OUT is held.
- FSM states: IDLE, LOAD, CALC, HOLD.
- IDLE: when START=1, latch MODE and SAT and go to LOAD. START seen in any other state is ignored.
- LOAD: IN_READY=1. A transfer occurs when IN_VALID&&IN_READY. Word index 0..KER*KER-1 writes kernel[r][c]; the following IMG*IMG words write image[r][c]. The cycle that accepts the last word goes to CALC. IN_VALID low stalls with no side effects.
- CALC: computes output (i,j), with i,j in 0..IMG-KER, in raster order. The result is the sum over r,c of image[i+r][j+c]*kernel[r][c], full width, no truncation.
  - MODE=0: one tap per cycle, taps in raster order. Takes KER*KER cycles.
  - MODE=1: one kernel row (KER taps summed) per cycle. Takes KER cycles.
  - The accumulator clears on entry to each output's first cycle. After the final tap cycle, go to HOLD.
- HOLD: OUT_VALID=1 and OUT_ACC holds the sum.
  - OUT = OUT_ACC[DW-1:0] if SAT=0. If SAT=1, OUT = all-ones when OUT_ACC > 2^DW-1, otherwise OUT_ACC[DW-1:0].
  - OUT_LAST=1 for output (IMG-KER, IMG-KER).
  - All outputs stay stable while OUT_READY=0.
  - On OUT_VALID&&OUT_READY: if not last, go to CALC for the next (i,j); if last, go to IDLE. OUT_VALID drops the following cycle.
- Latency: first OUT_VALID is asserted KER*KER cycles (MODE=0) or KER cycles (MODE=1) after the first CALC cycle.
- Steady state with OUT_READY tied high: one output per KER*KER+1 cycles (MODE=0) or KER+1 cycles (MODE=1).
- A run yields exactly (IMG-KER+1)^2 outputs. A new START is accepted the cycle after returning to IDLE.
- Arithmetic is unsigned throughout. Products are 2*DW bits; sums are ACC_W bits.

Test Plan:
- DW=8, IMG=4, KER=3, MODE=0, SAT=0. Kernel all 1, image all 1 -> four outputs, OUT=9, OUT_ACC=9, OUT_LAST only on the 4th. First OUT_VALID occurs 9 cycles after CALC entry.
- Kernel with centre 1 and others 0; image 1..16 raster; MODE=1 -> OUT=6, 7, 10, 11 in order. First OUT_VALID occurs 3 cycles after CALC entry.
- Kernel and image all 255, OUT_READY=1.
  - SAT=1 -> OUT=255, OUT_ACC=585225.
  - Rerun with SAT=0 -> OUT=9 (0x8EE09 low byte).
- Backpressure: OUT_READY held 0 for 5 cycles in HOLD -> OUT/OUT_ACC/OUT_VALID stable. Exactly one transfer on release, and no output is lost or duplicated.
- Load stalls: IN_VALID toggled every other cycle during LOAD -> identical results to the unstalled run. START pulses during LOAD/CALC are ignored.
- Reset mid-run: RST=0 for 1 cycle during CALC of the 2nd output -> next cycle IDLE, BUSY=0, OUT_VALID=0, OUT_ACC=0. A fresh full run then produces correct results.
